// File: rtl/rv_mul_ctrl_pkg.sv
// Shared state encoding and byte-pair step table for the byte-sliced multiply sequencer.
package rv_mul_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_ACC   = 2'd1,
    MC_DONE  = 2'd2,
    MC_ABORT = 2'd3
  } mc_state_e;

  localparam int MUL_NSTEPS = 10;

  // a-byte lane of each low-half pair, ordered by increasing i+j
  function automatic logic [1:0] step_i(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd3, 4'd6: step_i = 2'd0;
      4'd2, 4'd4, 4'd7:       step_i = 2'd1;
      4'd5, 4'd8:             step_i = 2'd2;
      4'd9:                   step_i = 2'd3;
      default:                step_i = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] step_j(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd2, 4'd5, 4'd9: step_j = 2'd0;
      4'd1, 4'd4, 4'd8:       step_j = 2'd1;
      4'd3, 4'd7:             step_j = 2'd2;
      4'd6:                   step_j = 2'd3;
      default:                step_j = 2'd0;
    endcase
  endfunction

  // i+j never exceeds 3 in the low half, so the 2-bit sum cannot overflow
  function automatic logic [4:0] step_shift(input logic [3:0] idx);
    logic [1:0] lane_sum;
    lane_sum   = step_i(idx) + step_j(idx);
    step_shift = {lane_sum, 3'b000};
  endfunction

endpackage

// File: rtl/rv_mul_step_sel.sv
// Finds the first enabled step at or after from_idx and reports its lanes, shift
// and whether any enabled step remains after it.
module rv_mul_step_sel
  import rv_mul_ctrl_pkg::*;
#(
  parameter int NSTEPS = MUL_NSTEPS
) (
  input  logic [3:0]        from_idx,
  input  logic [NSTEPS-1:0] mask,
  output logic [3:0]        nxt_idx,
  output logic [1:0]        nxt_i,
  output logic [1:0]        nxt_j,
  output logic [4:0]        nxt_shift,
  output logic              last
);

  // priority search downward so the lowest qualifying index wins
  always_comb begin
    nxt_idx = 4'd0;
    for (int n = NSTEPS - 1; n >= 0; n--) begin
      nxt_idx = (mask[n] && (4'(n) >= from_idx)) ? 4'(n) : nxt_idx;
    end
    last = 1'b1;
    for (int n = 0; n < NSTEPS; n++) begin
      last = (mask[n] && (4'(n) > nxt_idx)) ? 1'b0 : last;
    end
    nxt_i     = step_i(nxt_idx);
    nxt_j     = step_j(nxt_idx);
    nxt_shift = step_shift(nxt_idx);
  end

endmodule

// File: rtl/rv_mul_ctrl.sv
// Multiply sequencer: walks the enabled low-half byte pairs, driving registered
// select/shift/accumulate strobes to the datapath, then pulses done.
module rv_mul_ctrl
  import rv_mul_ctrl_pkg::*;
#(
  parameter int SKIP_ZERO = 1,
  parameter int NSTEPS    = MUL_NSTEPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] a_byte_nz,
  input  logic [3:0] b_byte_nz,
  output logic       busy,
  output logic       done,
  output logic [1:0] Ma_sel,
  output logic [1:0] Mb_sel,
  output logic [4:0] Mshift_val,
  output logic       Mupd_prod,
  output logic       Mclr_prod
);

  mc_state_e         state_r, state_s;
  logic [3:0]        idx_r, idx_s;
  logic [NSTEPS-1:0] mask_r, mask_s;
  logic              last_r, last_s;
  logic [NSTEPS-1:0] raw_mask_s, new_mask_s, sel_mask_s;
  logic [3:0]        sel_from_s;
  logic [3:0]        nxt_idx_s;
  logic [1:0]        nxt_i_s, nxt_j_s;
  logic [4:0]        nxt_shift_s;
  logic              nxt_last_s;
  logic              busy_s, done_s, upd_s, clr_s;
  logic [1:0]        asel_s, bsel_s;
  logic [4:0]        shift_s;

  // enable mask offered on start; pairs touching a zero byte contribute nothing
  always_comb begin
    raw_mask_s = '0;
    for (int n = 0; n < NSTEPS; n++) begin
      raw_mask_s[n] = (SKIP_ZERO != 0)
                    ? (a_byte_nz[step_i(4'(n))] & b_byte_nz[step_j(4'(n))])
                    : 1'b1;
    end
  end

  // an all-zero product still issues step 0 so the accumulator is written once
  assign new_mask_s = (raw_mask_s == '0) ? {{(NSTEPS-1){1'b0}}, 1'b1} : raw_mask_s;
  assign sel_from_s = (state_r == MC_ACC) ? (idx_r + 4'd1) : 4'd0;
  assign sel_mask_s = (state_r == MC_ACC) ? mask_r : new_mask_s;

  rv_mul_step_sel #(.NSTEPS(NSTEPS)) u_step_sel (
    .from_idx  (sel_from_s),
    .mask      (sel_mask_s),
    .nxt_idx   (nxt_idx_s),
    .nxt_i     (nxt_i_s),
    .nxt_j     (nxt_j_s),
    .nxt_shift (nxt_shift_s),
    .last      (nxt_last_s)
  );

  // next state and the output values that state will present after the edge
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    mask_s  = mask_r;
    last_s  = last_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    upd_s   = 1'b0;
    clr_s   = 1'b0;
    asel_s  = 2'd0;
    bsel_s  = 2'd0;
    shift_s = 5'd0;
    case (state_r)
      MC_IDLE: begin
        if (start && !abort) begin
          state_s = MC_ACC;
          mask_s  = new_mask_s;
          idx_s   = nxt_idx_s;
          last_s  = nxt_last_s;
          busy_s  = 1'b1;
          upd_s   = 1'b1;
          asel_s  = nxt_i_s;
          bsel_s  = nxt_j_s;
          shift_s = nxt_shift_s;
        end else begin
          state_s = MC_IDLE;
        end
      end
      MC_ACC: begin
        busy_s = 1'b1;
        if (abort) begin
          state_s = MC_ABORT;
          upd_s   = 1'b1;
          clr_s   = 1'b1;
        end else if (last_r) begin
          state_s = MC_DONE;
          done_s  = 1'b1;
        end else begin
          state_s = MC_ACC;
          idx_s   = nxt_idx_s;
          last_s  = nxt_last_s;
          upd_s   = 1'b1;
          asel_s  = nxt_i_s;
          bsel_s  = nxt_j_s;
          shift_s = nxt_shift_s;
        end
      end
      MC_DONE:  state_s = MC_IDLE;
      MC_ABORT: state_s = MC_IDLE;
      default:  state_s = MC_IDLE;
    endcase
  end

  // state, step bookkeeping and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= MC_IDLE;
      idx_r      <= 4'd0;
      mask_r     <= '0;
      last_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      Ma_sel     <= 2'd0;
      Mb_sel     <= 2'd0;
      Mshift_val <= 5'd0;
      Mupd_prod  <= 1'b0;
      Mclr_prod  <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      mask_r     <= mask_s;
      last_r     <= last_s;
      busy       <= busy_s;
      done       <= done_s;
      Ma_sel     <= asel_s;
      Mb_sel     <= bsel_s;
      Mshift_val <= shift_s;
      Mupd_prod  <= upd_s;
      Mclr_prod  <= clr_s;
    end
  end

endmodule

// File: tb/tb_rv_mul_ctrl.sv
// Self-checking bench: queue-based behavioural model of the sequence plus an emulated
// accumulator datapath, directed scenarios and randomized start/abort traffic.
module tb_rv_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [3:0]  a_byte_nz, b_byte_nz;
  logic        busy, done, upd, clr;
  logic [1:0]  asel, bsel;
  logic [4:0]  shift;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [4:0] shift;
    logic       upd;
    logic       clr;
  } outs_t;

  localparam outs_t DONE_REC  = '{busy: 1'b1, done: 1'b1, asel: 2'd0, bsel: 2'd0, shift: 5'd0, upd: 1'b0, clr: 1'b0};
  localparam outs_t ABORT_REC = '{busy: 1'b1, done: 1'b0, asel: 2'd0, bsel: 2'd0, shift: 5'd0, upd: 1'b1, clr: 1'b1};

  outs_t       cur = '0;
  outs_t       q[$];
  logic [31:0] acc = 32'd0;
  int          sh_log[10];
  int          sh_cnt;
  logic [8:0]  first_sel;

  always #5 clk = ~clk;

  assign a_byte_nz = {|a[31:24], |a[23:16], |a[15:8], |a[7:0]};
  assign b_byte_nz = {|b[31:24], |b[23:16], |b[15:8], |b[7:0]};

  rv_mul_ctrl #(.SKIP_ZERO(1), .NSTEPS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .a_byte_nz  (a_byte_nz),
    .b_byte_nz  (b_byte_nz),
    .busy       (busy),
    .done       (done),
    .Ma_sel     (asel),
    .Mb_sel     (bsel),
    .Mshift_val (shift),
    .Mupd_prod  (upd),
    .Mclr_prod  (clr)
  );

  function automatic outs_t acc_rec(input int i, input int j);
    outs_t r;
    r.busy  = 1'b1;
    r.done  = 1'b0;
    r.asel  = 2'(i);
    r.bsel  = 2'(j);
    r.shift = 5'(8 * (i + j));
    r.upd   = 1'b1;
    r.clr   = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] pp_of(input logic [31:0] av, input logic [31:0] bv,
                                        input logic [1:0] i, input logic [1:0] j,
                                        input logic [4:0] sh);
    logic [31:0] x;
    x = {24'd0, av[int'(i) * 8 +: 8]} * {24'd0, bv[int'(j) * 8 +: 8]};
    return x << sh;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[k * 8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: sequence of expected output records, plus the datapath accumulator
  always @(posedge clk) begin
    outs_t nxt;
    if (rst) begin
      q.delete();
      cur <= '0;
      acc <= 32'd0;
    end else begin
      if (cur.upd && !cur.clr && abort) begin
        q.delete();
        nxt = ABORT_REC;
      end else if (q.size() != 0) begin
        nxt = q.pop_front();
      end else if (!cur.busy && start && !abort) begin
        for (int s = 0; s < 4; s++) begin
          for (int i = 0; i <= s; i++) begin
            if (a[8 * i +: 8] != 8'd0 && b[8 * (s - i) +: 8] != 8'd0) q.push_back(acc_rec(i, s - i));
          end
        end
        if (q.size() == 0) q.push_back(acc_rec(0, 0));
        q.push_back(DONE_REC);
        nxt = q.pop_front();
      end else begin
        nxt = '0;
      end
      cur <= nxt;
      acc <= upd ? (clr ? 32'd0 : acc + pp_of(a, b, asel, bsel, shift)) : 32'd0;
    end
  end

  // compare process: every output on every cycle, and the product whenever done
  always @(negedge clk) begin
    outs_t       e;
    logic [31:0] prod;
    e    = rst ? outs_t'('0) : cur;
    prod = a * b;
    chk("outputs", {busy, done, asel, bsel, shift, upd, clr}, e);
    if (!rst && e.done) chk("product", acc, prod);
  end

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] res, input int lat);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    first_sel = {asel, bsel, shift};
    sh_cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (upd && !clr && sh_cnt < 10) begin
        sh_log[sh_cnt] = int'(shift);
        sh_cnt++;
      end
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
    chk("latency", n, lat);
    chk("result", acc, res);
  endtask

  initial begin
    int exp_sh[10] = '{0, 8, 8, 16, 16, 16, 24, 24, 24, 24};
    int n;

    #1 rst = 1'b1;
    #1 chk("reset_outputs", {busy, done, asel, bsel, shift, upd, clr}, 13'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // all bytes nonzero: every pair issues
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 11);
    chk("shift_count", sh_cnt, 10);
    for (int k = 0; k < 10; k++) chk("shift_seq", sh_log[k], exp_sh[k]);

    run_op(32'd3, 32'd5, 32'h0000_000F, 2);
    chk("single_sel", first_sel, {2'd0, 2'd0, 5'd0});

    run_op(32'h00FF_0000, 32'h0000_0100, 32'hFF00_0000, 2);
    chk("lane_sel", first_sel, {2'd2, 2'd1, 5'd24});

    run_op(32'd0, 32'h1234_5678, 32'd0, 2);
    chk("forced_sel", first_sel, {2'd0, 2'd0, 5'd0});

    // abort on the 4th ACC cycle, then a fresh op
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cycle", {upd, clr, busy, done}, 4'b1110);
    @(negedge clk);
    chk("abort_idle", {busy, done}, 2'b00);
    run_op(32'h0102_0304, 32'h0506_0708, 32'h0102_0304 * 32'h0506_0708, 11);

    // start during ACC and during DONE are ignored
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      start = (n == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency_restart", n, 11);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", busy, 1'b0);

    // start together with abort in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 1'b0);

    // asynchronous reset between edges mid-sequence
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_async", {busy, done, asel, bsel, shift, upd, clr}, 13'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", busy, 1'b0);
    end

    // randomized traffic against the model
    repeat (600) begin
      @(negedge clk);
      if (!cur.busy) begin
        if ($urandom_range(0, 3) == 0) begin
          a = rand_word();
          b = rand_word();
        end
        start = ($urandom_range(0, 2) == 0);
        abort = ($urandom_range(0, 7) == 0);
      end else begin
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 11) == 0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_mul_ctrl.md
Name: rv_mul_ctrl

Overview:
Sequencer for the byte-sliced multiply extension of the multicycle RISC-V datapath. On a start pulse from the main control FSM it walks the byte-pair partial products that contribute to the low 32 bits of a*b. For each pair it drives the operand-byte selects, shift amount and accumulate/clear strobes, then pulses done when the datapath result register holds the product. Optional zero-byte skipping shortens the sequence.

Parameters:
SKIP_ZERO, 1, 1 = omit pairs whose a-byte or b-byte was flagged zero at start; 0 = always issue all 10 pairs
NSTEPS, 10, number of low-half byte pairs (i+j<=3); fixed for a 32-bit datapath

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request from main FSM; a/b operand registers are valid and stable until done
abort  input  1  flush request (trap or kill) while busy
a_byte_nz  input  4  bit k = (a[8k+7:8k] != 0), sampled on accepted start
b_byte_nz  input  4  same for b
busy  output  1  high from cycle after accepted start until the DONE/ABORT cycle inclusive
done  output  1  one-cycle pulse: datapath result register holds (a*b) mod 2^32
Ma_sel  output  2  a byte-lane select i
Mb_sel  output  2  b byte-lane select j
Mshift_val  output  5  partial-product shift, 8*(i+j): only 0/8/16/24
Mupd_prod  output  1  accumulate enable; datapath accumulator clears whenever low
Mclr_prod  output  1  clear accumulator (takes effect after that cycle's add)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, Ma_sel, Mb_sel, Mshift_val, Mupd_prod, Mclr_prod all 0; step mask cleared.
- All outputs registered (Moore); no combinational path from inputs to outputs.
- Step table, fixed order, index 0..9: (i,j) = (0,0),(0,1),(1,0),(0,2),(1,1),(2,0),(0,3),(1,2),(2,1),(3,0). Mshift_val = 8*(i+j).
- States: IDLE, ACC, DONE, ABORT.
- IDLE: start=1 and abort=0 → latch 10-bit enable mask (bit n = a_byte_nz[i]&b_byte_nz[j] if SKIP_ZERO, else 1). If mask is all zero, force bit 0 so at least one step issues (contributes 0). Go to ACC at the first enabled index. start with abort in the same cycle → stay IDLE.
- ACC: Mupd_prod=1, Mclr_prod=0, Ma_sel/Mb_sel/Mshift_val from the current index. Mupd_prod must stay high on consecutive cycles for the whole sequence; no bubbles. Next cycle goes to the next enabled index. After the last enabled index → DONE.
- DONE: Mupd_prod=0, done=1, busy=1 for exactly one cycle, then IDLE. start is ignored here.
- abort=1 during ACC → next cycle is ABORT: Mupd_prod=1, Mclr_prod=1, selects 0, busy=1, done=0. Then IDLE. done never pulses for an aborted op. abort in DONE or IDLE is ignored.
- start while busy: ignored, no queuing.
- Latency: N enabled steps → N ACC cycles. done is asserted N+1 cycles after the accepted start edge. Full sequence: 11 cycles.
- Sel/shift outputs return to 0 in IDLE, DONE and ABORT.

Decomposition:
- Add to params.inc: state encodings (MC_IDLE, MC_ACC, MC_DONE, MC_ABORT), MUL_NSTEPS=10, and step-table constants for i/j per index.
- One sub-module, rv_mul_step_sel: combinational. Given the current index and the 10-bit mask, returns next enabled index, its (i,j,shift), and a last flag.
- rv_mul_ctrl holds the FSM, mask register and output registers.

Test Plan:
- a=0xFFFFFFFF, b=0xFFFFFFFF, SKIP_ZERO=1, start → 10 ACC cycles in table order, Mshift 0,8,8,16,16,16,24,24,24,24; done at start+11; result 0x00000001.
- a=3, b=5 (nz masks 0001/0001) → single ACC (0,0,0); done at start+2; result 0x0000000F.
- a=0x00FF0000, b=0x00000100 → single ACC with Ma_sel=2, Mb_sel=1, Mshift_val=24; result 0xFF000000. With a=0: forced step (0,0), result 0.
- Full 10-step op with abort on the 4th ACC cycle → next cycle Mupd_prod=1 and Mclr_prod=1, then IDLE; done never asserted; a new start 1 cycle later completes normally.
- start re-asserted during ACC and during DONE → ignored; start+abort together in IDLE → no operation begins.
- rst asserted mid-ACC (between edges) → all outputs 0 immediately; after release, idle until the next start.
